// File: rtl/bus_arbit_pkg.sv
// Shared constants and helpers for the round-robin bus arbiter.
// Optional hold timeout is enabled by defining BUS_ARBIT_TIMEOUT_EN.
package bus_arbit_pkg;

    localparam int BUS_M_MAX     = 16;
    localparam int PARK_IDX      = 0;
    localparam int HOLD_CNT_W    = 8;
    localparam int BUS_IDX_MAX_W = $clog2(BUS_M_MAX);

    // OR-reduction encoder: valid only for a one-hot input, which the grant always is.
    function automatic logic [BUS_IDX_MAX_W-1:0] onehot_to_idx(input logic [BUS_M_MAX-1:0] oh);
        logic [BUS_IDX_MAX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < BUS_M_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | BUS_IDX_MAX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbit_rr_rr_pick.sv
// Combinational rotate-and-find: first set req bit at or after 'start', wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [W:0]     sum;

    always_comb begin
        req_dbl = {req, req} >> start;
        req_rot = req_dbl[N-1:0];
        found   = 1'b0;
        idx     = '0;
        sum     = '0;
        // Descending scan so the smallest rotation offset wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                sum = {1'b0, start} + (W + 1)'(k);
                if (sum >= (W + 1)'(N)) begin
                    sum = sum - (W + 1)'(N);
                end
                found = 1'b1;
                idx   = sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbit_rr.sv
// N-master sticky round-robin bus arbiter, parks on master 0 when idle.
// Define BUS_ARBIT_TIMEOUT_EN to force rotation after MAX_HOLD owned cycles when others wait.
module bus_arbit_rr
    import bus_arbit_pkg::*;
#(
    parameter int NUM_M    = 4,
    parameter int IDX_W    = $clog2(NUM_M),
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NUM_M-1:0] req,
    output logic [NUM_M-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             arb_change
);

    if (NUM_M < 2 || NUM_M > BUS_M_MAX) begin : g_bad_num_m
        $error("bus_arbit_rr: NUM_M out of range");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("bus_arbit_rr: MAX_HOLD out of range");
    end

    logic [NUM_M-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             change_q, change_d;

    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] start;
    logic [NUM_M-1:0] req_others;
    logic             owner_req;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             timeout;

    always_comb begin
        owner      = IDX_W'(onehot_to_idx(BUS_M_MAX'(grant_q)));
        start      = (owner == IDX_W'(NUM_M - 1)) ? '0 : owner + IDX_W'(1);
        req_others = req & ~grant_q;
        owner_req  = |(req & grant_q);
    end

    // The owner is masked out, so the same scan serves both release and forced rotation.
    rr_pick #(
        .N (NUM_M),
        .W (IDX_W)
    ) u_pick (
        .req   (req_others),
        .start (start),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef BUS_ARBIT_TIMEOUT_EN
    localparam logic [HOLD_CNT_W-1:0] HOLD_LIM = HOLD_CNT_W'(MAX_HOLD - 1);

    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    always_comb begin
        timeout = (hold_cnt_q == HOLD_LIM) && pick_found;
        if (change_d) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q == '1) begin
            hold_cnt_d = hold_cnt_q;
        end else begin
            hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    always_comb begin
        timeout = 1'b0;
    end
`endif

    always_comb begin
        idx_d = owner;
        if (owner_req && !timeout) begin
            idx_d = owner;
        end else if (pick_found) begin
            idx_d = pick_idx;
        end else if (owner_req) begin
            idx_d = owner;
        end else begin
            idx_d = IDX_W'(PARK_IDX);
        end
        grant_d  = NUM_M'(1) << idx_d;
        change_d = (idx_d != owner);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q  <= NUM_M'(1);
            idx_q    <= IDX_W'(PARK_IDX);
            change_q <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            change_q <= change_d;
        end
    end

    assign grant      = grant_q;
    assign grant_idx  = idx_q;
    assign arb_change = change_q;

endmodule

// File: tb/tb_bus_arbit_rr.sv
// Self-checking bench for bus_arbit_rr: directed scenarios plus randomized runs on
// NUM_M = 4, 2 and 5 against a list-scan reference model.
module tb_bus_arbit_rr;

    localparam int MAX_HOLD = 8;
`ifdef BUS_ARBIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic [3:0] req4, grant4;
    logic [1:0] idx4;
    logic       chg4;
    logic [1:0] req2, grant2;
    logic       idx2;
    logic       chg2;
    logic [4:0] req5, grant5;
    logic [2:0] idx5;
    logic       chg5;

    logic [15:0] rq[3];
    logic [15:0] g_obs[3];
    int          i_obs[3];
    logic        c_obs[3];

    int m_owner[3];
    int m_hold[3];
    bit m_chg[3];

    int n_tests = 0;
    int n_fail = 0;

    logic [3:0] exp_q[$];

    assign req4 = rq[0][3:0];
    assign req2 = rq[1][1:0];
    assign req5 = rq[2][4:0];

    always_comb begin
        g_obs[0] = 16'(grant4);
        g_obs[1] = 16'(grant2);
        g_obs[2] = 16'(grant5);
        i_obs[0] = int'(idx4);
        i_obs[1] = int'(idx2);
        i_obs[2] = int'(idx5);
        c_obs[0] = chg4;
        c_obs[1] = chg2;
        c_obs[2] = chg5;
    end

    bus_arbit_rr #(.NUM_M(4), .MAX_HOLD(MAX_HOLD)) dut4 (
        .clk(clk), .reset_n(reset_n), .req(req4), .grant(grant4), .grant_idx(idx4), .arb_change(chg4)
    );
    bus_arbit_rr #(.NUM_M(2), .MAX_HOLD(MAX_HOLD)) dut2 (
        .clk(clk), .reset_n(reset_n), .req(req2), .grant(grant2), .grant_idx(idx2), .arb_change(chg2)
    );
    bus_arbit_rr #(.NUM_M(5), .MAX_HOLD(MAX_HOLD)) dut5 (
        .clk(clk), .reset_n(reset_n), .req(req5), .grant(grant5), .grant_idx(idx5), .arb_change(chg5)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int dut_n(input int d);
        case (d)
            0: return 4;
            1: return 2;
            default: return 5;
        endcase
    endfunction

    // Walks the masters after the owner in rotation order; plain list semantics.
    function automatic int model_next(input int owner, input logic [15:0] r, input int n, input int hold);
        int  nxt;
        bit  others;
        nxt = 0;
        others = 1'b0;
        for (int k = 1; k < n; k++) begin
            if (!others && r[(owner + k) % n]) begin
                nxt = (owner + k) % n;
                others = 1'b1;
            end
        end
        if (r[owner] && !(TO_EN && hold == MAX_HOLD - 1 && others)) return owner;
        if (others) return nxt;
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_owner[d] = 0;
            m_hold[d] = 0;
            m_chg[d] = 1'b0;
        end
    endtask

    task automatic tick();
        int nxt[3];
        for (int d = 0; d < 3; d++) begin
            nxt[d] = model_next(m_owner[d], rq[d], dut_n(d), m_hold[d]);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            m_chg[d] = (nxt[d] != m_owner[d]);
            if (m_chg[d]) m_hold[d] = 0;
            else if (m_hold[d] < 255) m_hold[d] = m_hold[d] + 1;
            m_owner[d] = nxt[d];
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (g_obs[d] !== 16'h0001 || i_obs[d] !== 0 || c_obs[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_immediate dut%0d: got grant=%h idx=%0d chg=%b, expected grant=0001 idx=0 chg=0",
                         d, g_obs[d], i_obs[d], c_obs[d]);
            end
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) rq[d] = '0;
        reset_n = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (grant4 !== 4'b0001 || idx4 !== 2'd0 || chg4 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: got grant=%b idx=%0d chg=%b, expected 0001/0/0", c, grant4, idx4, chg4);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++;
            if (grant4 !== 4'b0001 || idx4 !== 2'd0 || chg4 !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_park cyc%0d: got grant=%b idx=%0d chg=%b, expected 0001/0/0", c, grant4, idx4, chg4);
            end
        end
    endtask

    task automatic test_legacy_two();
        logic [1:0] lg_req[8];
        logic [1:0] lg_exp[8];
        logic [1:0] prev;
        lg_req = '{2'b00, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        lg_exp = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
        for (int d = 0; d < 3; d++) rq[d] = '0;
        do_reset();
        prev = 2'b01;
        for (int s = 0; s < 8; s++) begin
            rq[1] = 16'(lg_req[s]);
            tick();
            n_tests++;
            if (grant2 !== lg_exp[s] || chg2 !== (lg_exp[s] != prev)) begin
                n_fail++;
                $display("FAIL legacy_two step%0d: got grant=%b chg=%b, expected grant=%b chg=%b",
                         s, grant2, chg2, lg_exp[s], lg_exp[s] != prev);
            end
            prev = lg_exp[s];
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        for (int d = 0; d < 3; d++) rq[d] = '0;
        do_reset();
        exp_q = {4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rq[0] = 16'hF;
        tick();
        exp_g = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            rq[0] = 16'hF & ~16'(exp_g);
            tick();
            exp_g = exp_q.pop_front();
            n_tests++;
            if (grant4 !== exp_g || chg4 !== 1'b1) begin
                n_fail++;
                $display("FAIL round_robin hand%0d: got grant=%b chg=%b, expected grant=%b chg=1", k, grant4, chg4, exp_g);
            end
            rq[0] = 16'hF;
            tick();
            n_tests++;
            if (grant4 !== exp_g || chg4 !== 1'b0) begin
                n_fail++;
                $display("FAIL round_robin hold%0d: got grant=%b chg=%b, expected grant=%b chg=0", k, grant4, chg4, exp_g);
            end
        end
    endtask

    task automatic test_same_edge();
        for (int d = 0; d < 3; d++) rq[d] = '0;
        do_reset();
        rq[0] = 16'b0100;
        tick();
        n_tests++;
        if (grant4 !== 4'b0100) begin
            n_fail++;
            $display("FAIL same_edge_setup: got grant=%b, expected 0100", grant4);
        end
        rq[0] = 16'b1000;
        tick();
        n_tests++;
        if (grant4 !== 4'b1000 || idx4 !== 2'd3 || chg4 !== 1'b1) begin
            n_fail++;
            $display("FAIL same_edge_handover: got grant=%b idx=%0d chg=%b, expected 1000/3/1", grant4, idx4, chg4);
        end
        rq[0] = 16'b0001;
        tick();
        n_tests++;
        if (grant4 !== 4'b0001 || chg4 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_to_zero: got grant=%b chg=%b, expected 0001/1", grant4, chg4);
        end
    endtask

    task automatic test_skip_withdrawn();
        logic [15:0] steps[4];
        logic [3:0]  exps[4];
        steps = '{16'b0010, 16'b0110, 16'b0010, 16'b1000};
        exps  = '{4'b0010, 4'b0010, 4'b0010, 4'b1000};
        for (int d = 0; d < 3; d++) rq[d] = '0;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            rq[0] = steps[s];
            tick();
            n_tests++;
            if (grant4 !== exps[s]) begin
                n_fail++;
                $display("FAIL skip_withdrawn step%0d: got grant=%b, expected %b", s, grant4, exps[s]);
            end
        end
    endtask

`ifdef BUS_ARBIT_TIMEOUT_EN
    task automatic test_timeout();
        for (int d = 0; d < 3; d++) rq[d] = '0;
        rq[0] = 16'b0011;
        do_reset();
        for (int t = 1; t <= 16; t++) begin
            tick();
            n_tests++;
            if (grant4 !== ((t < 8 || t == 16) ? 4'b0001 : 4'b0010)) begin
                n_fail++;
                $display("FAIL timeout_hold t%0d: got grant=%b, expected %b",
                         t, grant4, (t < 8 || t == 16) ? 4'b0001 : 4'b0010);
            end
        end
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (grant4 !== 4'b0001 || idx4 !== 2'd0 || chg4 !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_midreset: got grant=%b idx=%0d chg=%b, expected 0001/0/0", grant4, idx4, chg4);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            n_tests++;
            if (grant4 !== ((t < 8) ? 4'b0001 : 4'b0010)) begin
                n_fail++;
                $display("FAIL timeout_after_reset t%0d: got grant=%b, expected %b", t, grant4, (t < 8) ? 4'b0001 : 4'b0010);
            end
        end
    endtask
`else
    task automatic test_hold_forever();
        for (int d = 0; d < 3; d++) rq[d] = '0;
        rq[0] = 16'b0011;
        do_reset();
        for (int t = 1; t <= 20; t++) begin
            tick();
            n_tests++;
            if (grant4 !== 4'b0001 || chg4 !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_forever t%0d: got grant=%b chg=%b, expected 0001/0", t, grant4, chg4);
            end
        end
    endtask
`endif

    task automatic test_random();
        int n;
        for (int d = 0; d < 3; d++) rq[d] = '0;
        do_reset();
        for (int it = 0; it < 400; it++) begin
            for (int d = 0; d < 3; d++) begin
                n = dut_n(d);
                if ($urandom_range(0, 3) == 0) begin
                    rq[d] = 16'($urandom_range(0, (1 << n) - 1));
                end else if ($urandom_range(0, 3) == 0) begin
                    rq[d][m_owner[d]] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    rq[d] = '0;
                end
            end
            tick();
            for (int d = 0; d < 3; d++) begin
                n_tests++;
                if (g_obs[d] !== (16'h0001 << m_owner[d]) || i_obs[d] !== m_owner[d] || c_obs[d] !== m_chg[d]) begin
                    n_fail++;
                    $display("FAIL random dut%0d it%0d: got grant=%h idx=%0d chg=%b, expected grant=%h idx=%0d chg=%b",
                             d, it, g_obs[d], i_obs[d], c_obs[d], 16'h0001 << m_owner[d], m_owner[d], m_chg[d]);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) rq[d] = '0;
        model_reset();
        test_reset();
        test_legacy_two();
        test_round_robin();
        test_same_edge();
        test_skip_withdrawn();
`ifdef BUS_ARBIT_TIMEOUT_EN
        test_timeout();
`else
        test_hold_forever();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbit_rr.md
Name: bus_arbit_rr

Overview:
- Parametrised N-master bus arbiter; successor to the two-master fixed arbiter.
- Sticky grant: the owner keeps the bus while it requests.
- On release, ownership rotates round-robin to the next requester; when idle, the bus parks on master 0.
- Sits between the bus masters and the shared bus mux; grant drives the address/data mux select.

Parameters:
- NUM_M, 4, number of masters (2..16).
- IDX_W, $clog2(NUM_M), width of grant_idx (derived; do not override).
- MAX_HOLD, 8, max consecutive owned cycles while others wait; used only with BUS_ARBIT_TIMEOUT_EN (range 2..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_M  per-master request; bit i = master i.
- grant  output  NUM_M  one-hot registered grant; exactly one bit set at all times.
- grant_idx  output  IDX_W  binary index of the granted master.
- arb_change  output  1  one-cycle pulse in the cycle after ownership changed.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are named clk and reset_n.
- Reset values (immediate on reset_n=0):
  - grant = 1 (master 0)
  - grant_idx = 0
  - arb_change = 0
  - hold counter = 0
- All outputs are registered. Decision at each rising edge uses the current req and the current owner. Latency from req change to grant update is 1 edge.
- Next-owner rules, priority order:
  1. req[owner]=1 and no timeout: keep owner.
  2. req[owner]=0: scan owner+1, owner+2, … modulo NUM_M, wrapping. The first set req bit becomes the new owner.
  3. No req bits set: park on master 0.
- Parking: a parked master 0 that raises req is already granted; no change and no arb_change pulse.
- arb_change is 1 for exactly the cycle following any edge where grant_idx changed, including a return to park.
- Simultaneous release by the owner and new requests by others: the rotation scan uses the same edge's req, so there is no idle cycle.
- Wrap-around: owner NUM_M-1 releasing with req[0] set hands the bus to master 0.
- A request withdrawn before it is granted is simply skipped; there is no latching of requests.
- Reset asserted mid-ownership returns to park immediately. On the first edge after release, normal rules apply.
- NUM_M need not be a power of 2. The scan never selects an index ≥ NUM_M.

Optional Feature:
- Macro: BUS_ARBIT_TIMEOUT_EN.
- Defined:
  - An 8-bit hold_cnt clears on every ownership change.
  - hold_cnt increments, saturating, each edge the owner is retained.
  - If hold_cnt == MAX_HOLD-1 and any other req bit is set, the next edge forces rotation to the next requester after the owner, even if req[owner]=1.
  - If no other master requests, the owner keeps the bus and hold_cnt saturates.
- Undefined:
  - No counter exists; ownership is held indefinitely while req[owner]=1.
  - MAX_HOLD is ignored.

Decomposition:
- Package bus_arbit_pkg holds:
  - BUS_M_MAX = 16
  - PARK_IDX = 0
  - HOLD_CNT_W = 8
  - function onehot_to_idx
- Sub-module rr_pick: combinational rotate-and-priority-find.
  - Inputs: req, start offset.
  - Outputs: found, idx.
  - Instantiated once in bus_arbit_rr.

Test Plan (NUM_M=4 unless noted):
1. Reset, req=0000 for 4 cycles -> grant=0001, grant_idx=0, arb_change=0 throughout.
2. NUM_M=2 legacy sequence. Expected grants per step: 01, 01, 10, 01, 10, 10, 01, 01.
   - req=11 -> grant=01
   - drop req0 -> 10
   - drop req1 -> 01
   - req1=1 -> 10
   - req0=1 -> stays 10
   - drop req1 -> 01
   - drop all -> 01
3. Round-robin: req=1111 held; each owner drops its req for one cycle in turn.
   - Grant sequence: 0001 -> 0010 -> 0100 -> 1000 -> 0001 (wrap).
   - arb_change pulses once per handover.
4. Same-edge handover: owner 2 drops req at the same edge req[3] rises -> grant=1000 on that edge, no parked cycle between.
5. Skip withdrawn: owner 1 holds; req[2] pulses for 1 cycle then clears; owner 1 releases with req[3]=1 -> grant=1000, master 2 never granted.
6. Timeout (BUS_ARBIT_TIMEOUT_EN, MAX_HOLD=8): req=0011 constant.
   - Master 0 is held exactly 8 cycles, then grant=0010.
   - Master 1 is held 8 cycles, then grant=0001.
   - Asserting reset_n=0 mid-hold -> grant=0001 immediately, hold_cnt=0.
